imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory writer and fetch responder for the single-cycle core. It receives a program as a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. It writes those words into a 32-entry instruction memory and serves the core's combinational fetch port. The core is held in reset (`cpu_hold`) until a complete program with a correct checksum has been loaded.

## Interface
Parameters:
- `DEPTH`, 32, number of instruction words.
- `ADDR_W`, 5, fetch/write address width; `DEPTH` = 2^`ADDR_W`.
- `INST_W`, 16, instruction width; fixed at two bytes.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and memory.
- `start`  in  1  one-cycle request to begin a load.
- `byte_valid`  in  1  `byte_data` is valid this cycle.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `fetch_addr`  in  `ADDR_W`  core instruction address.
- `fetch_inst`  out  `INST_W`  instruction at `fetch_addr`, combinational.
- `cpu_hold`  out  1  drive to the core's reset; high while no valid program is loaded.
- `load_done`  out  1  one-cycle pulse on successful load.
- `load_error`  out  1  sticky; the last load failed.

## Operation
Stream format: a count byte N (1..32), then 2N instruction bytes (high byte first), then a checksum byte equal to the XOR of the count byte and all instruction bytes.

A byte is accepted at a rising edge where `byte_valid & byte_ready`. No other byte is consumed.

State machine:
- IDLE: `byte_ready`=0.
  - `start` → COUNT.
- COUNT: `byte_ready`=1.
  - Accept N. If N=0 or N>32 → ERROR.
  - Otherwise latch N, clear `waddr` to 0, set chk=N → HI.
- HI: `byte_ready`=1.
  - Accept byte into the hi register; chk ^= byte → LO.
- LO: `byte_ready`=1.
  - Accept byte; write mem[`waddr`] <= {hi, byte}; chk ^= byte.
  - If `waddr`==N-1 → CHECK; else `waddr`+1 → HI.
- CHECK: `byte_ready`=1.
  - Accept byte. If it equals chk → DONE; otherwise → ERROR.
- DONE: `byte_ready`=0, `cpu_hold`=0.
  - `start` → COUNT.
- ERROR: `byte_ready`=0, `cpu_hold`=1, `load_error`=1.
  - `start` → COUNT.

Rules:
- `cpu_hold`=1 in every state except DONE.
- `start` in COUNT/HI/LO/CHECK is ignored.
- `start` in DONE or ERROR:
  - sets `cpu_hold`=1 and clears `load_error` at the same edge;
  - begins a new load.
- Memory words at addresses ≥ N keep their previous contents.
- `waddr` never wraps, because N ≤ 32.
- chk is 8-bit XOR; there is no carry.
- `fetch_inst` = mem[`fetch_addr`] in every state, including partially loaded memory during a load.

## Timing
Reset values: state IDLE, `cpu_hold`=1, `byte_ready`=0, `load_done`=0, `load_error`=0, all memory words 0, chk=0, `waddr`=0.

Reset mid-load aborts immediately. There is no partial-load recovery.

Handshake:
- `byte_ready` is a registered function of state.
- `start` at edge E0 → `byte_ready`=1 from E0.
- With `byte_valid` held high, one byte is consumed per cycle. A full load spans 2N+2 accepts after the `start` edge.

Memory write:
- A write at the LO accept edge is visible on `fetch_inst` immediately after that edge.
- A same-cycle read returns the old word.

Completion:
- On the checksum accept edge E, `cpu_hold` falls and `load_done` rises.
- `load_done` falls at E+1.
- `load_done` is never asserted on an error.

Error timing: ERROR is entered at the edge that accepted the offending byte (count or checksum). `load_error` is high from that edge.

## Test plan
- Reset, then no stimulus → `cpu_hold`=1, `byte_ready`=0, `fetch_inst`=0x0000 for every `fetch_addr`.
- `start`; bytes 01,12,34,27 back-to-back →
  - mem[0]=0x1234;
  - `cpu_hold` falls at the 4th accept;
  - `load_done` high exactly one cycle;
  - `fetch_addr`=0 gives 0x1234.
- `start`; bytes 02,A0,01,02,03,A2 with `byte_valid` toggling every other cycle → mem[0]=0xA001, mem[1]=0x0203, DONE; no byte is lost or duplicated.
- `start`; bytes 01,12,34,00 (bad checksum) →
  - ERROR: `load_error`=1 and `cpu_hold`=1;
  - mem[0]=0x1234 is still written;
  - a further `start` clears `load_error` and reloads.
- `start` with count byte 00, and separately with count byte 21 → ERROR after one accept; no memory write.
- Assert `reset` after the HI accept in a load → all outputs return to reset values asynchronously; mem[0] reads 0x0000.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader and combinational fetch port for the core.
// Holds the core in reset until a full, checksum-clean program is written.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [INST_W-1:0] fetch_inst,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        hi_q;
    logic [7:0]        chk_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_q;
    logic [INST_W-1:0] mem [DEPTH];

    logic accept;
    logic count_ok;
    logic last_word;

    assign accept     = byte_valid & byte_ready;
    assign count_ok   = (byte_data != 8'd0) && (byte_data <= MAX_N);
    assign last_word  = (waddr_q == last_q);

    assign byte_ready = (state == COUNT) || (state == HI) ||
                        (state == LO) || (state == CHECK);
    assign cpu_hold   = (state != DONE);
    assign load_error = (state == ERROR);
    assign load_done  = done_q;
    assign fetch_inst = mem[fetch_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = COUNT;
            COUNT: if (accept) state_nx = count_ok ? HI : ERROR;
            HI:    if (accept) state_nx = LO;
            LO:    if (accept) state_nx = last_word ? CHECK : HI;
            CHECK: if (accept) state_nx = (byte_data == chk_q) ? DONE : ERROR;
            DONE:  if (start) state_nx = COUNT;
            ERROR: if (start) state_nx = COUNT;
            default: state_nx = IDLE;
        endcase
    end

    // last_q holds N-1 so the final-word compare stays ADDR_W wide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q    <= '0;
            chk_q   <= '0;
            last_q  <= '0;
            waddr_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                unique case (state)
                    COUNT: begin
                        last_q  <= ADDR_W'(byte_data - 8'd1);
                        waddr_q <= '0;
                        chk_q   <= byte_data;
                    end
                    HI: begin
                        hi_q  <= byte_data;
                        chk_q <= chk_q ^ byte_data;
                    end
                    LO: begin
                        mem[waddr_q] <= {hi_q, byte_data};
                        chk_q        <= chk_q ^ byte_data;
                        if (!last_word) begin
                            waddr_q <= waddr_q + 1'b1;
                        end
                    end
                    CHECK: begin
                        done_q <= (byte_data == chk_q);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, handshake gaps, checksum and
// count errors, and asynchronous reset mid-load.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [4:0]  fetch_addr;
    logic [15:0] fetch_inst;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int vectors = 0;
    int errors  = 0;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .fetch_addr (fetch_addr),
        .fetch_inst (fetch_inst),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !byte_ready; i++) tick();
        check("ready_wait", 16'(byte_ready), 16'd1);
        tick();
    endtask

    task automatic gap();
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
        tick();
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [15:0] exp);
        fetch_addr = a;
        #1;
        check(tag, fetch_inst, exp);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        fetch_addr = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_hold", 16'(cpu_hold), 16'd1);
        check("rst_ready", 16'(byte_ready), 16'd0);
        check("rst_done", 16'(load_done), 16'd0);
        check("rst_err", 16'(load_error), 16'd0);
        for (int i = 0; i < 32; i++) rd("rst_mem", 5'(i), 16'h0000);

        // single word load, back to back
        pulse_start();
        check("t1_ready", 16'(byte_ready), 16'd1);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        rd("t1_early_mem0", 5'd0, 16'h1234);
        check("t1_hold_pre", 16'(cpu_hold), 16'd1);
        check("t1_done_pre", 16'(load_done), 16'd0);
        send(8'h27);
        byte_valid = 1'b0;
        check("t1_hold", 16'(cpu_hold), 16'd0);
        check("t1_done", 16'(load_done), 16'd1);
        check("t1_err", 16'(load_error), 16'd0);
        tick();
        check("t1_done_fall", 16'(load_done), 16'd0);
        check("t1_hold_low", 16'(cpu_hold), 16'd0);
        check("t1_ready_low", 16'(byte_ready), 16'd0);
        rd("t1_mem0", 5'd0, 16'h1234);

        // two words, valid toggling
        pulse_start();
        check("t2_hold_start", 16'(cpu_hold), 16'd1);
        send(8'h02); gap();
        send(8'hA0); gap();
        send(8'h01); gap();
        send(8'h02); gap();
        send(8'h03);
        byte_valid = 1'b0;
        check("t2_not_done", 16'(load_done), 16'd0);
        tick();
        send(8'hA2);
        byte_valid = 1'b0;
        check("t2_done", 16'(load_done), 16'd1);
        check("t2_hold", 16'(cpu_hold), 16'd0);
        rd("t2_mem0", 5'd0, 16'hA001);
        rd("t2_mem1", 5'd1, 16'h0203);
        rd("t2_mem2", 5'd2, 16'h0000);

        // bad checksum
        pulse_start();
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h00);
        byte_valid = 1'b0;
        check("t3_err", 16'(load_error), 16'd1);
        check("t3_hold", 16'(cpu_hold), 16'd1);
        check("t3_done", 16'(load_done), 16'd0);
        check("t3_ready", 16'(byte_ready), 16'd0);
        rd("t3_mem0", 5'd0, 16'h1234);
        rd("t3_mem1_kept", 5'd1, 16'h0203);
        tick();
        check("t3_err_sticky", 16'(load_error), 16'd1);
        pulse_start();
        check("t3_err_clr", 16'(load_error), 16'd0);
        check("t3_hold_restart", 16'(cpu_hold), 16'd1);
        send(8'h01);
        send(8'h55);
        send(8'h66);
        send(8'h32);
        byte_valid = 1'b0;
        check("t3_reload_done", 16'(load_done), 16'd1);
        check("t3_reload_hold", 16'(cpu_hold), 16'd0);
        rd("t3_reload_mem0", 5'd0, 16'h5566);

        // count 0 and count 33
        pulse_start();
        send(8'h00);
        byte_valid = 1'b0;
        check("t4_zero_err", 16'(load_error), 16'd1);
        check("t4_zero_ready", 16'(byte_ready), 16'd0);
        check("t4_zero_hold", 16'(cpu_hold), 16'd1);
        rd("t4_zero_mem0", 5'd0, 16'h5566);
        pulse_start();
        check("t4_big_clr", 16'(load_error), 16'd0);
        send(8'h21);
        byte_valid = 1'b0;
        check("t4_big_err", 16'(load_error), 16'd1);
        check("t4_big_done", 16'(load_done), 16'd0);
        rd("t4_big_mem0", 5'd0, 16'h5566);

        // async reset after the HI accept
        pulse_start();
        send(8'h01);
        send(8'hAB);
        byte_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t5_hold", 16'(cpu_hold), 16'd1);
        check("t5_ready", 16'(byte_ready), 16'd0);
        check("t5_err", 16'(load_error), 16'd0);
        check("t5_done", 16'(load_done), 16'd0);
        rd("t5_mem0", 5'd0, 16'h0000);
        rd("t5_mem1", 5'd1, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        check("t5_idle_ready", 16'(byte_ready), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
